clksynth_lock_supervisor: RTL and testbench

Supervises the ADC clock synthesizer status pins and drives the bicolor, active-low front-panel status LED. It synchronizes and debounces the PLL lock and input-clock loss signals, then tracks synthesizer health in a four-state FSM. It also keeps a sticky lock-loss flag and a saturating loss counter for slow-control readout. Sits in the `clk` domain next to the synthesizer SPI configuration logic and replaces any direct combinational LED drive.

---
 rtl/clksynth_lock_supervisor.sv | 261 ++++++++++++++++++++++++++
 tb/tb_clksynth_lock_supervisor.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clksynth_lock_supervisor.sv
// ---------------------------------------------------------------------------
// clksynth_lock_supervisor
//
// Watches the ADC clock synthesizer status pins. It synchronizes and
// debounces them, tracks synthesizer health in a four-state FSM, keeps a
// sticky lock-loss flag and a saturating loss counter, and drives the
// bicolor, active-low front-panel status LED.
//
// Optional feature macro: CLKSYNTH_LOSS_COUNTER_EN
//   defined     : loss_count counts LOCKED->LOST transitions and saturates
//   not defined : loss_count is tied to 0. Everything else is unchanged.
//
// Ports
//   clk                 in  system clock (single domain)
//   rst_n               in  asynchronous active-low reset
//   adcclk_ld           in  PLL2 lock detect, async, 1 = locked
//   adcclk_stat         in  PLL1 lock detect, async, 1 = locked
//   adcclk_clkin0_stat  in  CLKin0 loss-of-signal, async, 1 = clock lost
//   clear_loss          in  one-cycle pulse, clears loss_flag/loss_count
//   red_led             out active low (0 = on)
//   green_led           out active low (0 = on)
//   state               out NO_INPUT=0, ACQUIRE=1, LOCKED=2, LOST=3
//   locked              out 1 while state is LOCKED
//   loss_flag           out sticky, set on each LOCKED->LOST transition
//   loss_count          out saturating count of LOCKED->LOST transitions
//
// Handshake: there are none. clear_loss is a plain level sampled on every
// clock edge, and a one-cycle pulse acts exactly once.
// ---------------------------------------------------------------------------
module clksynth_lock_supervisor #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BLINK_HALF      = 25000000,
    parameter int LOSS_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adcclk_ld,
    input  logic                  adcclk_stat,
    input  logic                  adcclk_clkin0_stat,
    input  logic                  clear_loss,
    output logic                  red_led,
    output logic                  green_led,
    output logic [1:0]            state,
    output logic                  locked,
    output logic                  loss_flag,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    typedef enum logic [1:0] {
        NO_INPUT = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        LOST     = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_HALF);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF - 1);
    localparam logic [BL_W-1:0] BL_ONE = BL_W'(1);

    // ---------------------------------------------------------------------
    // 2-FF synchronizers. The loss-of-signal pair resets to "lost", so
    // the supervisor never trusts the input clock straight out of reset.
    // ---------------------------------------------------------------------
    logic ld_s1, ld_s2, stat_s1, stat_s2, los_s1, los_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_s1   <= 1'b0;
            ld_s2   <= 1'b0;
            stat_s1 <= 1'b0;
            stat_s2 <= 1'b0;
            los_s1  <= 1'b1;
            los_s2  <= 1'b1;
        end else begin
            ld_s1   <= adcclk_ld;
            ld_s2   <= ld_s1;
            stat_s1 <= adcclk_stat;
            stat_s2 <= stat_s1;
            los_s1  <= adcclk_clkin0_stat;
            los_s2  <= los_s1;
        end
    end

    // Index 0 = PLL condition, index 1 = input-clock condition.
    logic [1:0] raw_ok;
    assign raw_ok = {~los_s2, ld_s2 & stat_s2};

    // ---------------------------------------------------------------------
    // Asymmetric debounce. A bad sample drops the output on the next edge.
    // A good output needs DEBOUNCE_CYCLES good samples already counted
    // *before* the current good sample, so that the output rises
    // DEBOUNCE_CYCLES edges later than the drop path would have reacted.
    // The counter parks at DEBOUNCE_CYCLES and never wraps.
    // ---------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      db_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
            db_ok <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!raw_ok[i]) begin
                    db_cnt[i] <= '0;
                    db_ok[i]  <= 1'b0;
                end else begin
                    if (db_cnt[i] != DB_MAX) begin
                        db_cnt[i] <= db_cnt[i] + DB_ONE;
                    end
                    db_ok[i] <= (db_cnt[i] == DB_MAX);
                end
            end
        end
    end

    logic pll_ok_db, in_ok_db;
    assign pll_ok_db = db_ok[0];
    assign in_ok_db  = db_ok[1];

    // ---------------------------------------------------------------------
    // Health FSM
    // ---------------------------------------------------------------------
    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NO_INPUT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NO_INPUT: if (in_ok_db) state_d = ACQUIRE;
            ACQUIRE: begin
                if (!in_ok_db)      state_d = NO_INPUT;
                else if (pll_ok_db) state_d = LOCKED;
            end
            LOCKED:   if (!in_ok_db || !pll_ok_db) state_d = LOST;
            // LOST only ever leaves by relocking.
            LOST:     if (in_ok_db && pll_ok_db) state_d = LOCKED;
            default:  state_d = NO_INPUT;
        endcase
    end

    logic loss_event, state_change;
    assign loss_event   = (state_q == LOCKED) && (state_d == LOST);
    assign state_change = (state_d != state_q);

    assign state  = state_q;
    assign locked = (state_q == LOCKED);

    // ---------------------------------------------------------------------
    // Loss bookkeeping. A loss in the same cycle as clear_loss wins.
    // ---------------------------------------------------------------------
    logic loss_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_flag_q <= 1'b0;
        end else if (loss_event) begin
            loss_flag_q <= 1'b1;
        end else if (clear_loss) begin
            loss_flag_q <= 1'b0;
        end
    end

    assign loss_flag = loss_flag_q;

`ifdef CLKSYNTH_LOSS_COUNTER_EN
    localparam logic [LOSS_CNT_W-1:0] CNT_ONE = LOSS_CNT_W'(1);
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if (loss_event) begin
            if (clear_loss) begin
                loss_cnt_q <= CNT_ONE;
            end else if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                loss_cnt_q <= loss_cnt_q + CNT_ONE;
            end
        end else if (clear_loss) begin
            loss_cnt_q <= '0;
        end
    end

    assign loss_count = loss_cnt_q;
`else
    assign loss_count = '0;
`endif

    // ---------------------------------------------------------------------
    // Blink generator. It restarts on every state change so that each LED
    // pattern begins in its "on" half. phase_q = 1 means the on half.
    // ---------------------------------------------------------------------
    logic [BL_W-1:0] blink_cnt;
    logic            phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_q   <= 1'b1;
        end else if (state_change) begin
            blink_cnt <= '0;
            phase_q   <= 1'b1;
        end else if (blink_cnt == BL_MAX) begin
            blink_cnt <= '0;
            phase_q   <= ~phase_q;
        end else begin
            blink_cnt <= blink_cnt + BL_ONE;
        end
    end

    // ---------------------------------------------------------------------
    // LED map, registered. The map never turns both colours on together.
    // ---------------------------------------------------------------------
    logic red_d, green_d;

    always_comb begin
        red_d   = 1'b1;
        green_d = 1'b1;
        case (state_q)
            NO_INPUT: red_d   = 1'b0;
            ACQUIRE:  green_d = ~phase_q;
            LOCKED: begin
                if (loss_flag_q) begin
                    // Alternate colours, with green in the on half.
                    green_d = ~phase_q;
                    red_d   = phase_q;
                end else begin
                    green_d = 1'b0;
                end
            end
            LOST:     red_d = ~phase_q;
            default: begin
                red_d   = 1'b1;
                green_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_led   <= 1'b0;
            green_led <= 1'b1;
        end else begin
            red_led   <= red_d;
            green_led <= green_d;
        end
    end

endmodule

// File: tb/tb_clksynth_lock_supervisor.sv
// ---------------------------------------------------------------------------
// Self-checking bench for clksynth_lock_supervisor (small parameters).
// The reference model tracks run lengths of good samples, the time spent in
// the current state, and the LED rule table. Outputs are compared on the
// falling clock edge. Inputs are also driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_clksynth_lock_supervisor;

  localparam int D  = 4;
  localparam int BH = 4;
  localparam int W  = 8;
  localparam int VW = W + 6;
  localparam int CNT_MAX = (1 << W) - 1;
`ifdef CLKSYNTH_LOSS_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---- clock / reset ------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic adcclk_ld = 1'b0;
  logic adcclk_stat = 1'b0;
  logic adcclk_clkin0_stat = 1'b1;
  logic clear_loss = 1'b0;
  logic red_led, green_led, locked, loss_flag;
  logic [1:0] state;
  logic [W-1:0] loss_count;

  always #5 clk = ~clk;

  clksynth_lock_supervisor #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_HALF(BH),
    .LOSS_CNT_W(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .adcclk_ld(adcclk_ld),
    .adcclk_stat(adcclk_stat),
    .adcclk_clkin0_stat(adcclk_clkin0_stat),
    .clear_loss(clear_loss),
    .red_led(red_led),
    .green_led(green_led),
    .state(state),
    .locked(locked),
    .loss_flag(loss_flag),
    .loss_count(loss_count)
  );

  int checks = 0;
  int failures = 0;

  // ---- reference model ----------------------------------------------------
  int m_state, m_t, m_count, run_pll, run_in;
  bit m_flag, m_red_n, m_green_n, db_pll, db_in;
  bit pll_q[$];
  bit in_q[$];

  // {red_n, green_n} for a state, a blink half and the sticky flag
  function automatic bit [1:0] led_rule(int st, bit on, bit flag);
    case (st)
      0: return 2'b01;
      1: return {1'b1, !on};
      2: return flag ? (on ? 2'b10 : 2'b01) : 2'b10;
      default: return {!on, 1'b1};
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_t = 0; m_count = 0; m_flag = 0;
    m_red_n = 0; m_green_n = 1;
    run_pll = 0; run_in = 0; db_pll = 0; db_in = 0;
    pll_q.delete(); in_q.delete();
    // synchronizer contents out of reset: PLL not locked, input lost
    pll_q.push_back(1'b0); pll_q.push_back(1'b0);
    in_q.push_back(1'b0); in_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit [1:0] led;
    bit raw_p, raw_i, on;
    int nxt;
    on = ((m_t / BH) % 2) == 0;
    led = led_rule(m_state, on, m_flag);
    raw_p = pll_q.pop_front();
    raw_i = in_q.pop_front();
    pll_q.push_back(adcclk_ld && adcclk_stat);
    in_q.push_back(!adcclk_clkin0_stat);
    nxt = m_state;
    case (m_state)
      0: if (db_in) nxt = 1;
      1: if (!db_in) nxt = 0; else if (db_pll) nxt = 2;
      2: if (!db_in || !db_pll) nxt = 3;
      default: if (db_in && db_pll) nxt = 2;
    endcase
    if (m_state == 2 && nxt == 3) begin
      m_flag = 1;
      if (CNT_EN) m_count = clear_loss ? 1 : ((m_count < CNT_MAX) ? m_count + 1 : m_count);
    end else if (clear_loss) begin
      m_flag = 0;
      m_count = 0;
    end
    m_t = (nxt != m_state) ? 0 : m_t + 1;
    m_state = nxt;
    run_pll = raw_p ? ((run_pll < D + 1) ? run_pll + 1 : run_pll) : 0;
    run_in  = raw_i ? ((run_in < D + 1) ? run_in + 1 : run_in) : 0;
    db_pll = run_pll >= D + 1;
    db_in  = run_in >= D + 1;
    m_red_n = led[1];
    m_green_n = led[0];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    return {2'(m_state), (m_state == 2), m_red_n, m_green_n, m_flag, W'(m_count)};
  endfunction

  // ---- driver tasks -------------------------------------------------------
  task automatic do_reset();
    rst_n = 1'b0;
    adcclk_ld = 1'b0; adcclk_stat = 1'b0; adcclk_clkin0_stat = 1'b1; clear_loss = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---- tests --------------------------------------------------------------
  task automatic test_reset();
    logic [VW-1:0] rst_vec;
    rst_vec = {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, W'(0)};
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, locked, red_led, green_led, loss_flag, loss_count} !== rst_vec) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h",
               {state, locked, red_led, green_led, loss_flag, loss_count}, rst_vec);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
    end
  endtask

  task automatic test_acquire();
    int first_acq, first_lock;
    first_acq = -1; first_lock = -1;
    adcclk_ld = 1'b1; adcclk_stat = 1'b1; adcclk_clkin0_stat = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL acquire cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
      if (state == 2'd1 && first_acq < 0) first_acq = i;
      if (state == 2'd2 && first_lock < 0) first_lock = i;
      if (i >= 6 + D) begin
        checks++;
        if ({red_led, green_led} !== 2'b10) begin
          failures++;
          $display("FAIL acquire_green_solid cyc %0d: got %b expected 10", i, {red_led, green_led});
        end
      end
    end
    checks++;
    if (first_acq != 4 + D) begin
      failures++;
      $display("FAIL acquire_latency: got %0d expected %0d", first_acq, 4 + D);
    end
    checks++;
    if (first_lock != 5 + D) begin
      failures++;
      $display("FAIL lock_latency: got %0d expected %0d", first_lock, 5 + D);
    end
  endtask

  task automatic test_glitch();
    int n;
    do_reset();
    adcclk_clkin0_stat = 1'b0; adcclk_stat = 1'b1; adcclk_ld = 1'b0;
    n = 0;
    while (state !== 2'd1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL glitch_reach_acquire: got %0d expected 1", state);
    end
    for (int i = 0; i < 45; i++) begin
      adcclk_ld = (i % 3 != 2);
      @(negedge clk);
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL glitch cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
      checks++;
      if (state === 2'd2 || loss_count !== W'(0)) begin
        failures++;
        $display("FAIL glitch_no_lock cyc %0d: got state %0d count %0d expected state 1 count 0",
                 i, state, loss_count);
      end
    end
  endtask

  task automatic test_loss_relock();
    int n, lost_at;
    adcclk_ld = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL loss_reach_locked: got %0d expected 2", state);
    end
    repeat (3) @(negedge clk);
    adcclk_stat = 1'b0;
    lost_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) adcclk_stat = 1'b1;
      if (state == 2'd3 && lost_at < 0) lost_at = i;
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL loss_relock cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
      checks++;
      if (red_led === 1'b0 && green_led === 1'b0) begin
        failures++;
        $display("FAIL both_leds_on cyc %0d: got 00 expected not 00", i);
      end
    end
    checks++;
    if (lost_at != 4) begin
      failures++;
      $display("FAIL loss_latency: got %0d expected 4", lost_at);
    end
    checks++;
    if ({state, loss_flag, loss_count} !== {2'd2, 1'b1, W'(CNT_EN ? 1 : 0)}) begin
      failures++;
      $display("FAIL relock_flag_count: got %h expected %h",
               {state, loss_flag, loss_count}, {2'd2, 1'b1, W'(CNT_EN ? 1 : 0)});
    end
    clear_loss = 1'b1;
    @(negedge clk);
    clear_loss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({red_led, green_led, loss_flag, loss_count} !== {1'b1, 1'b0, 1'b0, W'(0)}) begin
        failures++;
        $display("FAIL cleared_green_solid cyc %0d: got %h expected %h", i,
                 {red_led, green_led, loss_flag, loss_count}, {1'b1, 1'b0, 1'b0, W'(0)});
      end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    adcclk_stat = 1'b0;
    @(negedge clk);
    adcclk_stat = 1'b1;
    n = 0;
    while (state !== 2'd3 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (state !== 2'd2 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
      failures++;
      $display("FAIL sim_pre: got %h expected %h",
               {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
    end
    // single-cycle drop: the loss event lands on the 4th edge after it
    adcclk_stat = 1'b0;
    @(negedge clk);
    adcclk_stat = 1'b1;
    repeat (2) @(negedge clk);
    clear_loss = 1'b1;
    @(negedge clk);
    clear_loss = 1'b0;
    checks++;
    if ({state, loss_flag, loss_count} !== {2'd3, 1'b1, W'(CNT_EN ? 1 : 0)}) begin
      failures++;
      $display("FAIL sim_loss_wins: got %h expected %h",
               {state, loss_flag, loss_count}, {2'd3, 1'b1, W'(CNT_EN ? 1 : 0)});
    end
    checks++;
    if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
      failures++;
      $display("FAIL sim_model: got %h expected %h",
               {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
    end
  endtask

  task automatic test_saturation();
    int n;
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 300 && ok; k++) begin
      n = 0;
      while (state !== 2'd2 && n < 30) begin @(negedge clk); n++; end
      if (state !== 2'd2) ok = 1'b0;
      adcclk_stat = 1'b0;
      @(negedge clk);
      adcclk_stat = 1'b1;
      n = 0;
      while (state !== 2'd3 && n < 10) begin @(negedge clk); n++; end
      if (state !== 2'd3) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL sat_loop_timeout: got state %0d expected loop to complete", state);
    end
    checks++;
    if (loss_count !== W'(CNT_EN ? CNT_MAX : 0) || W'(m_count) !== loss_count) begin
      failures++;
      $display("FAIL sat_count: got %0d expected %0d", loss_count, CNT_EN ? CNT_MAX : 0);
    end
  endtask

  task automatic test_los_in_acquire();
    int n;
    do_reset();
    adcclk_clkin0_stat = 1'b0;
    n = 0;
    while (state !== 2'd1 && n < 30) begin @(negedge clk); n++; end
    adcclk_clkin0_stat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL los_acquire cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
    end
    checks++;
    if ({state, red_led, green_led, loss_flag, loss_count} !== {2'd0, 1'b0, 1'b1, 1'b0, W'(0)}) begin
      failures++;
      $display("FAIL los_to_no_input: got %h expected %h",
               {state, red_led, green_led, loss_flag, loss_count}, {2'd0, 1'b0, 1'b1, 1'b0, W'(0)});
    end
  endtask

  task automatic test_reset_mid();
    int n, first_acq;
    adcclk_clkin0_stat = 1'b0; adcclk_ld = 1'b1; adcclk_stat = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 30) begin @(negedge clk); n++; end
    adcclk_stat = 1'b0;
    n = 0;
    while (state !== 2'd3 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (state !== 2'd3 || loss_flag !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_reach_lost: got state %0d flag %b expected state 3 flag 1", state, loss_flag);
    end
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, locked, red_led, green_led, loss_flag, loss_count} !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, W'(0)}) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h",
               {state, locked, red_led, green_led, loss_flag, loss_count},
               {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, W'(0)});
    end
    @(negedge clk);
    adcclk_stat = 1'b1;
    rst_n = 1'b1;
    first_acq = -1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (state == 2'd1 && first_acq < 0) first_acq = i;
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL rstmid_requalify cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
    end
    checks++;
    if (first_acq != 4 + D) begin
      failures++;
      $display("FAIL rstmid_debounce_restart: got %0d expected %0d", first_acq, 4 + D);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      adcclk_ld = ($urandom_range(0, 29) != 0);
      adcclk_stat = ($urandom_range(0, 29) != 0);
      adcclk_clkin0_stat = ($urandom_range(0, 59) == 0);
      clear_loss = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      checks++;
      if ({state, locked, red_led, green_led, loss_flag, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc %0d: got %h expected %h", i,
                 {state, locked, red_led, green_led, loss_flag, loss_count}, exp_vec());
      end
    end
    clear_loss = 1'b0;
  endtask

  // ---- sequence and report ------------------------------------------------
  initial begin
    test_reset();
    test_acquire();
    test_glitch();
    test_loss_relock();
    test_simultaneous();
    test_saturation();
    test_los_in_acquire();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
